// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache front end with a
// valid/ready backing-memory port. Optional uncached window: DCACHE_RESPONDER_UNCACHED_EN.
module dcache_responder #(
   parameter int LOG2_LINES = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] dcache_addr,
   input  logic        dcache_re,
   input  logic [3:0]  dcache_we,
   input  logic [31:0] dcache_din,
   output logic [31:0] dcache_dout,
   output logic        stall,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_req_rw,
   output logic [29:0] mem_req_addr,
   output logic [31:0] mem_req_data,
   output logic [3:0]  mem_req_mask,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data
);

   // state | meaning
   // IDLE  | lookup; load hits complete here, misses/stores leave
   // RREQ  | read request presented to memory
   // RWAIT | waiting for read data
   // WREQ  | write-through request presented to memory
   // WDONE | one-cycle release so the held access is not reissued
   typedef enum logic [2:0] {IDLE, RREQ, RWAIT, WREQ, WDONE} state_t;

   localparam int LINES = 1 << LOG2_LINES;
   localparam int TAG_W = 30 - LOG2_LINES;

   state_t state, state_nxt;

   logic [31:0]           data_arr [LINES];
   logic [TAG_W-1:0]      tag_arr  [LINES];
   logic [LINES-1:0]      valid_arr;

   logic [LOG2_LINES-1:0] idx;
   logic [TAG_W-1:0]      tag;
   logic                  store;
   logic                  bypass;
   logic                  hit;
   logic                  load_hit;
   logic                  fill_en;
   logic                  merge_en;
   logic                  bypass_rd;
   logic                  unused_addr_bits;

   assign idx   = dcache_addr[LOG2_LINES+1:2];
   assign tag   = dcache_addr[31:LOG2_LINES+2];
   assign store = |dcache_we;

`ifdef DCACHE_RESPONDER_UNCACHED_EN
   assign bypass = dcache_addr[31];
`else
   assign bypass = 1'b0;
`endif

   assign hit = valid_arr[idx] && (tag_arr[idx] == tag) && !bypass;

   // The pipeline is frozen while stall is high, so driving the request
   // fields straight from the presented access keeps them stable.
   assign mem_req_addr     = dcache_addr[31:2];
   assign mem_req_data     = dcache_din;
   assign mem_req_mask     = dcache_we;
   assign unused_addr_bits = ^dcache_addr[1:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      stall         = 1'b0;
      mem_req_valid = 1'b0;
      mem_req_rw    = 1'b0;
      load_hit      = 1'b0;
      fill_en       = 1'b0;
      merge_en      = 1'b0;
      bypass_rd     = 1'b0;
      case (state)
         IDLE: begin
            if (store) begin
               stall     = 1'b1;
               state_nxt = WREQ;
            end else if (dcache_re && !hit) begin
               stall     = 1'b1;
               state_nxt = RREQ;
            end else if (dcache_re) begin
               load_hit = 1'b1;
            end
         end
         RREQ: begin
            mem_req_valid = 1'b1;
            stall         = 1'b1;
            if (mem_req_ready) state_nxt = RWAIT;
         end
         RWAIT: begin
            stall = 1'b1;
            if (mem_resp_valid) begin
               if (bypass) begin
                  bypass_rd = 1'b1;
                  state_nxt = WDONE;
               end else begin
                  fill_en   = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         WREQ: begin
            mem_req_valid = 1'b1;
            mem_req_rw    = 1'b1;
            stall         = 1'b1;
            if (mem_req_ready) begin
               merge_en  = hit;
               state_nxt = WDONE;
            end
         end
         WDONE:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (fill_en) begin
         data_arr[idx] <= mem_resp_data;
         tag_arr[idx]  <= tag;
      end else if (merge_en) begin
         for (int b = 0; b < 4; b++) begin
            if (dcache_we[b]) data_arr[idx][8*b +: 8] <= dcache_din[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)       valid_arr      <= '0;
      else if (fill_en) valid_arr[idx] <= 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)         dcache_dout <= '0;
      else if (load_hit)  dcache_dout <= data_arr[idx];
      else if (bypass_rd) dcache_dout <= mem_resp_data;
   end

endmodule

// File: tb/tb_dcache_responder.sv
// Self-checking bench for dcache_responder: behavioural backing memory plus
// scoreboards for load data, expected memory reads and expected memory writes.
module tb_dcache_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] dcache_addr;
   logic        dcache_re;
   logic [3:0]  dcache_we;
   logic [31:0] dcache_din;
   logic [31:0] dcache_dout;
   logic        stall;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_req_rw;
   logic [29:0] mem_req_addr;
   logic [31:0] mem_req_data;
   logic [3:0]  mem_req_mask;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;

   dcache_responder #(.LOG2_LINES(6)) dut (
      .clk(clk), .reset(reset),
      .dcache_addr(dcache_addr), .dcache_re(dcache_re), .dcache_we(dcache_we),
      .dcache_din(dcache_din), .dcache_dout(dcache_dout), .stall(stall),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
      .mem_req_data(mem_req_data), .mem_req_mask(mem_req_mask),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
   );

   initial forever #5 clk = ~clk;

   typedef struct packed {
      logic [29:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
   } wr_t;

   int errors = 0;
   int checks = 0;

   logic [31:0] mem_model [logic [29:0]];
   logic [31:0] dout_q [$];
   logic [29:0] rd_exp_q [$];
   wr_t         wr_exp_q [$];
   logic [31:0] last_dout = 32'h0;

   int          rdy_dly = 0;
   int          rsp_dly = 1;
   int          rd_cnt = 0;
   int          wr_cnt = 0;
   bit          pend_rd = 1'b0;
   int          rcnt = 0;
   int          wcnt = 0;
   logic [31:0] rd_data;
   logic        cap_rw;
   logic [29:0] cap_addr;
   logic [31:0] cap_data;
   logic [3:0]  cap_mask;

   function automatic logic [31:0] model_rd(input logic [29:0] wa);
      if (mem_model.exists(wa)) return mem_model[wa];
      return {2'b10, wa} ^ 32'h3C3C_0000;
   endfunction

   // Backing memory: ready after rdy_dly cycles of valid, read data rsp_dly cycles after acceptance.
   initial begin : mem_responder
      wr_t         got;
      wr_t         exp;
      logic [31:0] tmp;
      logic [29:0] ea;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = 32'h0;
      forever begin
         @(negedge clk);
         mem_resp_valid = 1'b0;
         if (pend_rd) begin
            if (rcnt <= 1) begin
               mem_resp_valid = 1'b1;
               mem_resp_data  = rd_data;
               pend_rd        = 1'b0;
            end else begin
               rcnt--;
            end
         end
         if (mem_req_ready) begin
            mem_req_ready = 1'b0;
            wcnt          = 0;
            checks++;
            if (!cap_rw) begin
               rd_cnt++;
               if (rd_exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL mem_read: unexpected read of word 0x%08h", cap_addr);
               end else begin
                  ea = rd_exp_q.pop_front();
                  if (cap_addr !== ea) begin
                     errors++;
                     $display("FAIL mem_read_addr: got 0x%08h expected 0x%08h", cap_addr, ea);
                  end
               end
               pend_rd = 1'b1;
               rcnt    = rsp_dly;
               rd_data = model_rd(cap_addr);
            end else begin
               wr_cnt++;
               got = {cap_addr, cap_data, cap_mask};
               if (wr_exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL mem_write: unexpected write word 0x%08h", cap_addr);
               end else begin
                  exp = wr_exp_q.pop_front();
                  if (got !== exp) begin
                     errors++;
                     $display("FAIL mem_write: got a=%08h d=%08h m=%b expected a=%08h d=%08h m=%b",
                              got.addr, got.data, got.mask, exp.addr, exp.data, exp.mask);
                  end
               end
               tmp = model_rd(cap_addr);
               for (int b = 0; b < 4; b++)
                  if (cap_mask[b]) tmp[8*b +: 8] = cap_data[8*b +: 8];
               mem_model[cap_addr] = tmp;
            end
         end else if (mem_req_valid === 1'b1 && reset === 1'b1) begin
            if (wcnt >= rdy_dly) begin
               mem_req_ready = 1'b1;
               cap_rw   = mem_req_rw;
               cap_addr = mem_req_addr;
               cap_data = mem_req_data;
               cap_mask = mem_req_mask;
            end else begin
               wcnt++;
            end
         end
      end
   end

   task automatic do_load(input logic [31:0] a, input bit exp_miss, input string nm);
      int          cyc;
      bit          first_stall;
      logic [31:0] e;
      @(posedge clk); #1;
      dcache_addr = a;
      dcache_re   = 1'b1;
      dcache_we   = 4'b0000;
      dcache_din  = 32'h0;
      dout_q.push_back(model_rd(a[31:2]));
      if (exp_miss) rd_exp_q.push_back(a[31:2]);
      @(negedge clk);
      first_stall = stall;
      cyc = 0;
      while (stall !== 1'b0 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (cyc >= 200) begin
         errors++;
         $display("FAIL %s_timeout: stall=%b still high after %0d cycles, required low", nm, stall, cyc);
      end
      checks++;
      if (first_stall !== exp_miss) begin
         errors++;
         $display("FAIL %s_miss: first-cycle stall=%b required %b", nm, first_stall, exp_miss);
      end
      @(posedge clk); #1;
      dcache_re = 1'b0;
      @(negedge clk);
      e = dout_q.pop_front();
      last_dout = e;
      checks++;
      if (dcache_dout !== e) begin
         errors++;
         $display("FAIL %s_dout: got 0x%08h required 0x%08h", nm, dcache_dout, e);
      end
   endtask

   task automatic do_store(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d,
                           input int min_req_cycles, input string nm);
      int cyc;
      int req_cycles;
      int w0;
      bit first_stall;
      @(posedge clk); #1;
      dcache_addr = a;
      dcache_re   = 1'b0;
      dcache_we   = m;
      dcache_din  = d;
      wr_exp_q.push_back({a[31:2], d, m});
      w0 = wr_cnt;
      @(negedge clk);
      first_stall = stall;
      cyc = 0;
      req_cycles = 0;
      while (stall !== 1'b0 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (mem_req_valid === 1'b1 && mem_req_ready === 1'b0) begin
            req_cycles++;
            checks++;
            if (mem_req_addr !== a[31:2] || mem_req_data !== d || mem_req_mask !== m ||
                mem_req_rw !== 1'b1 || stall !== 1'b1) begin
               errors++;
               $display("FAIL %s_hold: a=%08h d=%08h m=%b rw=%b stall=%b required a=%08h d=%08h m=%b rw=1 stall=1",
                        nm, mem_req_addr, mem_req_data, mem_req_mask, mem_req_rw, stall, a[31:2], d, m);
            end
         end
      end
      checks++;
      if (first_stall !== 1'b1 || cyc >= 200) begin
         errors++;
         $display("FAIL %s_stall: first stall=%b cycles=%0d required stall=1 and release", nm, first_stall, cyc);
      end
      @(posedge clk); #1;
      dcache_we  = 4'b0000;
      dcache_din = 32'h0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (wr_cnt - w0 !== 1) begin
         errors++;
         $display("FAIL %s_count: writes=%0d required 1", nm, wr_cnt - w0);
      end
      checks++;
      if (req_cycles < min_req_cycles) begin
         errors++;
         $display("FAIL %s_backpressure: held cycles=%0d required >=%0d", nm, req_cycles, min_req_cycles);
      end
      checks++;
      if (dcache_dout !== last_dout) begin
         errors++;
         $display("FAIL %s_dout_hold: got 0x%08h required 0x%08h", nm, dcache_dout, last_dout);
      end
   endtask

   task automatic test_reset();
      reset       = 1'b0;
      dcache_addr = 32'h0;
      dcache_re   = 1'b0;
      dcache_we   = 4'b0000;
      dcache_din  = 32'h0;
      repeat (3) @(negedge clk);
      checks++;
      if (stall !== 1'b0 || mem_req_valid !== 1'b0 || dcache_dout !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs: stall=%b valid=%b dout=%08h required 0 0 00000000",
                  stall, mem_req_valid, dcache_dout);
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || mem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: stall=%b valid=%b required 0 0", stall, mem_req_valid);
      end
   endtask

   task automatic test_read_miss_hit();
      rdy_dly = 2;
      rsp_dly = 3;
      mem_model[30'h40] = 32'hDEAD_BEEF;
      do_load(32'h0000_0100, 1'b1, "read_miss");
      do_load(32'h0000_0100, 1'b0, "read_hit");
   endtask

   task automatic test_store_hit();
      rdy_dly = 0;
      rsp_dly = 1;
      do_store(32'h0000_0100, 4'b0010, 32'h0000_AB00, 0, "store_hit");
      do_load(32'h0000_0100, 1'b0, "store_merge");
   endtask

   task automatic test_conflict();
      do_load(32'h0000_0200, 1'b1, "evict_miss");
      do_load(32'h0000_0100, 1'b1, "evict_reload");
      do_store(32'h0000_0200, 4'b1111, 32'hCAFE_F00D, 0, "store_miss");
      do_load(32'h0000_0100, 1'b0, "store_miss_keep");
      do_load(32'h0000_0200, 1'b1, "store_miss_noalloc");
   endtask

   task automatic test_backpressure();
      rdy_dly = 5;
      do_store(32'h0000_0104, 4'b1100, 32'h1234_5678, 5, "backpressure");
      do_load(32'h0000_0104, 1'b1, "backpressure_load");
      rdy_dly = 0;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         rdy_dly = $urandom_range(0, 3);
         rsp_dly = $urandom_range(1, 4);
         do_load(32'h0000_0400 + 32'(4 * i), 1'b1, "b2b_miss");
      end
      for (int i = 0; i < 4; i++) do_load(32'h0000_0400 + 32'(4 * i), 1'b0, "b2b_hit");
      rdy_dly = 0;
      rsp_dly = 1;
   endtask

   task automatic test_reset_mid_rwait();
      int cyc;
      int r0;
      rsp_dly = 6;
      r0 = rd_cnt;
      @(posedge clk); #1;
      dcache_addr = 32'h0000_0140;
      dcache_re   = 1'b1;
      rd_exp_q.push_back(30'h50);
      cyc = 0;
      while (rd_cnt == r0 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      @(negedge clk);
      reset     = 1'b0;
      dcache_re = 1'b0;
      #1;
      last_dout = 32'h0;
      checks++;
      if (cyc >= 50 || mem_req_valid !== 1'b0 || stall !== 1'b0 || dcache_dout !== 32'h0) begin
         errors++;
         $display("FAIL reset_rwait: cyc=%0d valid=%b stall=%b dout=%08h required valid=0 stall=0 dout=0",
                  cyc, mem_req_valid, stall, dcache_dout);
      end
      @(negedge clk);
      reset = 1'b1;
      cyc = 0;
      while (pend_rd && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      repeat (2) @(negedge clk);
      checks++;
      if (dcache_dout !== 32'h0 || stall !== 1'b0) begin
         errors++;
         $display("FAIL late_resp: dout=%08h stall=%b required 00000000 0", dcache_dout, stall);
      end
      rsp_dly = 2;
      do_load(32'h0000_0140, 1'b1, "post_reset_miss");
   endtask

   task automatic test_uncached();
`ifdef DCACHE_RESPONDER_UNCACHED_EN
      do_load(32'h0000_0100, 1'b1, "unc_prime");
      do_load(32'h8000_0100, 1'b1, "unc_load1");
      do_load(32'h8000_0100, 1'b1, "unc_load2");
      do_store(32'h8000_0100, 4'b1111, 32'h55AA_55AA, 0, "unc_store");
      do_load(32'h8000_0100, 1'b1, "unc_load3");
      do_load(32'h0000_0100, 1'b0, "unc_cache_kept");
`else
      do_load(32'h8000_0000, 1'b1, "hi_addr_miss");
      do_load(32'h8000_0000, 1'b0, "hi_addr_hit");
`endif
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_read_miss_hit();
      test_store_hit();
      test_conflict();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_rwait();
      test_uncached();
      repeat (4) @(negedge clk);
      checks++;
      if (rd_exp_q.size() != 0 || wr_exp_q.size() != 0 || dout_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: reads=%0d writes=%0d loads=%0d left, required 0 0 0",
                  rd_exp_q.size(), wr_exp_q.size(), dout_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dcache_responder.md
DCACHE_RESPONDER -- requirements
Module: dcache_responder

Interface
REQ-001 Parameter LOG2_LINES, default 6, sets log2 of the number of one-word cache lines.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 dcache_addr  input  32  byte address from the pipeline execute stage.
REQ-005 dcache_re  input  1  load request.
REQ-006 dcache_we  input  4  byte-lane store mask; 0 means no store.
REQ-007 dcache_din  input  32  lane-aligned store data.
REQ-008 dcache_dout  output  32  load data, registered, valid the cycle after the load is accepted.
REQ-009 stall  output  1  combinational; high freezes the pipeline.
REQ-010 mem_req_valid  output  1  backing-memory request valid.
REQ-011 mem_req_ready  input  1  backing memory accepts the request.
REQ-012 mem_req_rw  output  1  1 = write, 0 = read.
REQ-013 mem_req_addr  output  30  word address, equal to dcache_addr[31:2].
REQ-014 mem_req_data  output  32  write data, equal to dcache_din.
REQ-015 mem_req_mask  output  4  write byte mask, equal to dcache_we.
REQ-016 mem_resp_valid  input  1  read data valid; accepted unconditionally.
REQ-017 mem_resp_data  input  32  read data word.

Function
REQ-018 The cache SHALL be direct-mapped and write-through with no write-allocate: index = addr[LOG2_LINES+1:2], tag = addr[31:LOG2_LINES+2], and each line holds a valid bit.
REQ-019 The FSM SHALL have states IDLE, RREQ, RWAIT, WREQ and WDONE.
REQ-020 IDLE: if dcache_we != 0, stall = 1, then go to WREQ; else if dcache_re and miss, stall = 1, then go to RREQ; else stall = 0.
REQ-021 If dcache_re and dcache_we are both active, the store SHALL take priority and the load SHALL be ignored.
REQ-022 Load hit in IDLE: dcache_dout SHALL be loaded with the line data at the next edge, giving 1-cycle latency and no stall.
REQ-023 RREQ: mem_req_valid = 1, mem_req_rw = 0, stall = 1; on mem_req_ready go to RWAIT.
REQ-024 RWAIT: stall = 1; on mem_resp_valid, write the data, tag and valid bit into the line, then go to IDLE, where the repeated lookup hits.
REQ-025 WREQ: mem_req_valid = 1, mem_req_rw = 1, stall = 1; on mem_req_ready, if the store hits, merge the enabled bytes into the line, then go to WDONE.
REQ-026 WDONE: stall = 0; the still-presented store SHALL NOT be reissued; go to IDLE next cycle.
REQ-027 mem_req_* outputs SHALL be held stable while mem_req_valid = 1 and mem_req_ready = 0.
REQ-028 A store miss SHALL leave the cache contents unchanged.
REQ-029 mem_req_valid SHALL be 0 in IDLE, RWAIT and WDONE.
REQ-030 dcache_dout SHALL hold its value in every cycle without a load hit.
REQ-031 A mem_resp_valid arriving outside RWAIT SHALL be ignored.

Reset
REQ-032 Assertion of reset (low) SHALL immediately force the FSM to IDLE, mem_req_valid to 0, dcache_dout to 0, and all valid bits to 0, including during an in-flight request.
REQ-033 After reset, stall SHALL be 0 while dcache_re = 0 and dcache_we = 0.
REQ-034 Data and tag arrays need no reset.

Configuration
REQ-035 With DCACHE_RESPONDER_UNCACHED_EN defined, any access with dcache_addr[31] = 1 SHALL bypass the cache.
REQ-036 A bypassed load SHALL always take RREQ/RWAIT, load mem_resp_data directly into dcache_dout, and leave the arrays unmodified; the FSM SHALL then pass through WDONE-like release with stall = 0 for one cycle before returning to IDLE.
REQ-037 A bypassed store SHALL never update the arrays.
REQ-038 Without DCACHE_RESPONDER_UNCACHED_EN, all addresses SHALL be cacheable.

Verification
REQ-039 Read miss then hit: load 0x0000_0100, ready after 2 cycles, resp 0xDEADBEEF 3 cycles later -> stall high until fill, dout = 0xDEADBEEF; a second load to 0x100 produces no stall and 1-cycle dout.
REQ-040 Store byte hit: after the fill above, we = 4'b0010, din = 0x0000_AB00 at 0x100 -> one mem write with mask 0010; a subsequent load returns 0xDEADABEF.
REQ-041 Conflict eviction (LOG2_LINES = 6): load 0x100, then load 0x200 (same index) -> second load misses; reloading 0x100 misses again.
REQ-042 Backpressure: mem_req_ready held low for 5 cycles -> mem_req_addr, mem_req_data and mem_req_mask stay constant and stall stays high throughout.
REQ-043 Reset mid-RWAIT: reset low while waiting -> mem_req_valid = 0, stall = 0, and a late mem_resp_valid is ignored; the next load to the same address misses.
REQ-044 Uncached (macro defined): load 0x8000_0000 twice -> both loads issue a memory read; cache contents are unchanged.
